// File: rtl/pe_accumulator.sv
// Accumulates LEN unsigned {carry, din} terms per group and offers the total on a
// valid/ready port. Optional macro PE_ACC_SATURATE_EN clamps on overflow instead of wrapping.
module pe_accumulator #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [BITWIDTH-1:0]  din,
  input  logic                 carry,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 overflow
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {ACC, DONE} state_t;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, term, acc_nxt;
  logic [ACC_WIDTH:0]   sum;
  logic [CW-1:0]        count;
  logic                 sticky, accept, last, add_ovf, release_out;

  always_comb begin
    term = '0;
    term[BITWIDTH:0] = {carry, din};
  end

  assign sum     = {1'b0, acc} + {1'b0, term};
  assign add_ovf = sum[ACC_WIDTH];
  assign last    = (count == CW'(LEN - 1));

`ifdef PE_ACC_SATURATE_EN
  // Once clamped, acc is all-ones so any non-zero term overflows again and stays clamped.
  assign acc_nxt = add_ovf ? '1 : sum[ACC_WIDTH-1:0];
`else
  assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    state_nxt   = state;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    accept      = 1'b0;
    release_out = 1'b0;
    case (state)
      ACC: begin
        din_ready = !clr;
        accept    = din_valid && !clr;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          release_out = 1'b1;
          state_nxt   = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      sticky   <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else if (release_out || (state == ACC && clr)) begin
      acc    <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else if (accept) begin
      acc    <= acc_nxt;
      sticky <= sticky | add_ovf;
      count  <= last ? '0 : count + CW'(1);
      if (last) begin
        dout     <= acc_nxt;
        overflow <= sticky | add_ovf;
      end
    end
  end

endmodule
